// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: opcode encodings,
// skid-FIFO state encodings and the buffered-entry payload type.
package alu_writeback_pkg;

    // ALU opcode encodings (sOP_*)
    localparam logic [2:0] sOP_NULL    = 3'b000;
    localparam logic [2:0] sOP_ADD     = 3'b001;
    localparam logic [2:0] sOP_SUB     = 3'b010;
    localparam logic [2:0] sOP_AND     = 3'b011;
    localparam logic [2:0] sOP_OR      = 3'b100;
    localparam logic [2:0] sOP_XOR     = 3'b101;
    localparam logic [2:0] sOP_PASS    = 3'b110;
    localparam logic [2:0] sOP_ILLEGAL = 3'b111;

    // Skid-FIFO occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // One buffered ALU result; bit 8 of result is carry/borrow
    typedef struct packed {
        logic [8:0] result;
        logic [2:0] opcode;
    } wb_payload_t;

    // Only arithmetic opcodes produce a meaningful carry/borrow
    function automatic logic op_sets_carry(input logic [2:0] op);
        return (op == sOP_ADD) || (op == sOP_SUB);
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Register file for the writeback stage: 2**ADDR_W x 8 bits,
// one synchronous write port, two asynchronous read ports.
// Reads never bypass the write in flight: same-cycle reads see the old value.
module wb_regfile #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [7:0]        rdata_a,
    output logic [7:0]        rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] regs_q [DEPTH];

    // Register write; every entry clears on reset
    // NOTE: the array is reset (not left as plain RAM) because software-visible registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: a 2-entry skid FIFO absorbs ALU results while the
// register-file write is stalled, then retires them in order into wb_regfile
// and updates the {carry, zero} flag register.
// Optional feature: define ALU_WRITEBACK_FLAGS_EN to implement the flag
// register; otherwise out_flags is tied to 2'b00.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    output logic              out_ready,
    input  logic [8:0]        in_result,
    input  logic [2:0]        s_opcode,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_stall,
    input  logic [ADDR_W-1:0] in_rd_a,
    input  logic [ADDR_W-1:0] in_rd_b,
    output logic [7:0]        out_a,
    output logic [7:0]        out_b,
    output logic [1:0]        out_flags,
    output logic              out_err
);

    logic [1:0]        state_q, state_d;
    logic              ready_q;
    logic              err_q;
    wb_payload_t       head_q, tail_q;
    logic [ADDR_W-1:0] head_dest_q, tail_dest_q;

    logic accept;
    logic retire;
    logic head_illegal;
    logic reg_we;

    assign accept       = in_valid && ready_q;
    assign retire       = (state_q != ST_EMPTY) && !in_stall;
    assign head_illegal = (head_q.opcode == sOP_ILLEGAL);
    assign reg_we       = retire && !head_illegal;

    // FIFO occupancy next-state
    // NOTE: state_d is defaulted first so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !retire)      state_d = ST_FULL;
                else if (!accept && retire) state_d = ST_EMPTY;
            end
            ST_FULL:  if (retire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // State, registered ready and the illegal-opcode error pulse
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            err_q   <= retire && head_illegal;
        end
    end

    // Payload storage: head is the oldest entry, tail the second one
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            head_dest_q <= '0;
            tail_dest_q <= '0;
        end else if (accept) begin
            if ((state_q == ST_EMPTY) || retire) begin
                head_q      <= '{result: in_result, opcode: s_opcode};
                head_dest_q <= in_dest;
            end else begin
                tail_q      <= '{result: in_result, opcode: s_opcode};
                tail_dest_q <= in_dest;
            end
        end else if ((state_q == ST_FULL) && retire) begin
            head_q      <= tail_q;
            head_dest_q <= tail_dest_q;
        end
    end

    wb_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .we      (reg_we),
        .waddr   (head_dest_q),
        .wdata   (head_q.result[7:0]),
        .raddr_a (in_rd_a),
        .raddr_b (in_rd_b),
        .rdata_a (out_a),
        .rdata_b (out_b)
    );

`ifdef ALU_WRITEBACK_FLAGS_EN
    logic carry_q, zero_q;

    // Flag update on retire of a legal opcode; sOP_NULL leaves both flags alone
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (reg_we) begin
            if (op_sets_carry(head_q.opcode)) carry_q <= head_q.result[8];
            if (head_q.opcode != sOP_NULL)    zero_q  <= (head_q.result[7:0] == 8'h00);
        end
    end

    assign out_flags = {carry_q, zero_q};
`else
    // Carry bit only feeds the flag register, which is not built here
    logic flags_unused;
    assign flags_unused = head_q.result[8];
    assign out_flags    = 2'b00;
`endif

    assign out_ready = ready_q;
    assign out_err   = err_q;

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter: ADDR_W, default 2, register index width; register file depth is 2**ADDR_W.
REQ-002 SHALL have port: in_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: in_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  ALU result/opcode/dest presented.
REQ-005 SHALL have port: out_ready  output  1  block can accept; transfer when in_valid && out_ready.
REQ-006 SHALL have port: in_result  input  9  ALU result; bit 8 = carry/borrow.
REQ-007 SHALL have port: s_opcode  input  3  opcode that produced in_result (sOP_* encoding).
REQ-008 SHALL have port: in_dest  input  ADDR_W  destination register index.
REQ-009 SHALL have port: in_stall  input  1  high blocks register-file write this cycle.
REQ-010 SHALL have ports: in_rd_a / in_rd_b  input  ADDR_W  read indexes for ALU operands.
REQ-011 SHALL have ports: out_a / out_b  output  8  combinational register-file read data (feeds ALU in_a/in_b).
REQ-012 SHALL have port: out_flags  output  2  {carry, zero} flag register.
REQ-013 SHALL have port: out_err  output  1  one-cycle pulse on dropped illegal-opcode entry.

Function
REQ-014 SHALL buffer accepted entries {result, opcode, dest} in a 2-entry skid FIFO with states EMPTY, ONE, FULL.
REQ-015 SHALL drive out_ready = 1 in EMPTY and ONE, 0 in FULL (registered, no combinational path from in_stall).
REQ-016 SHALL retire the oldest entry each cycle the FIFO is non-empty and in_stall is 0.
REQ-017 SHALL transition: EMPTY->ONE on accept; ONE->FULL on accept without retire; ONE->EMPTY on retire without accept; FULL->ONE on retire; simultaneous accept+retire holds state.
REQ-018 SHALL write result[7:0] to register in_dest on retire, visible on out_a/out_b the following cycle (accept-to-visible latency 2 cycles minimum when unstalled).
REQ-019 SHALL not bypass: a read of a register being written in the same cycle returns the old value.
REQ-020 SHALL on retire of sOP_ADD/sOP_SUB set carry = result[8]; on any legal opcode except sOP_NULL set zero = (result[7:0]==0); sOP_NULL writes the register but leaves flags unchanged.
REQ-021 SHALL on retire of opcode 3'b111 (undefined) discard the entry, write nothing, leave flags, and pulse out_err for exactly that cycle.
REQ-022 SHALL ignore in_valid, s_opcode, in_result, in_dest when out_ready is 0.

Reset
REQ-023 SHALL on in_rst_n low immediately clear FIFO to EMPTY, all registers to 8'h00, out_flags to 2'b00, out_err to 0, out_ready to 1.
REQ-024 SHALL discard buffered entries on reset mid-operation; no write occurs in the reset-release cycle.

Configuration
REQ-025 SHALL honour macro ALU_WRITEBACK_FLAGS_EN: defined -> flag register implemented per REQ-020; undefined -> no flag storage, out_flags tied 2'b00; all other behaviour identical.

Structure
REQ-026 SHALL take sOP_* opcode values from the shared definitions header; add sOP_ILLEGAL (3'b111) and FIFO state encodings there.
REQ-027 SHALL place the register file (2**ADDR_W x 8, one write, two async reads) in one sub-module named wb_regfile.

Verification
REQ-028 SHALL cover: ADD result 9'h100 to dest 1 -> R1=8'h00, out_flags=2'b11 two cycles later.
REQ-029 SHALL cover: in_stall=1 with 3 back-to-back valids -> first two accepted, out_ready=0 third cycle, no writes until stall drops, then two writes in order.
REQ-030 SHALL cover: opcode 3'b111 -> out_err one-cycle pulse, registers and flags unchanged.
REQ-031 SHALL cover: sOP_NULL with in_result 9'h05 to dest 2 after flags=2'b01 -> R2=8'h05, flags stay 2'b01.
REQ-032 SHALL cover: in_rst_n asserted while FULL -> out_ready=1, all registers 0, no write after release.
REQ-033 SHALL cover: write R3=8'hAA with in_rd_a=3 same cycle -> out_a old value, 8'hAA next cycle.
